// File: rtl/uart_image_loader.sv
// UART byte receiver that streams an image into BRAM, one write pulse per pixel.
// Loads are armed by a load_en rising edge and finish after IMG_PIXELS good bytes.
module uart_image_loader #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned IMG_PIXELS   = 65536
) (
    input  logic        clk,
    input  logic        btnC,
    input  logic        rx,
    input  logic        load_en,
    output logic        we,
    output logic [15:0] addr,
    output logic [7:0]  din,
    output logic        busy,
    output logic        done,
    output logic        frame_err
);

    localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned CNT_W  = 17;
    localparam logic [BAUD_W-1:0] BIT_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0]  PIX_END   = CNT_W'(IMG_PIXELS);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_e;

    rx_state_e         state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              rx_meta, rx_s, rx_s_d;
    logic              byte_ok_c, byte_bad_c;
    logic              load_en_d;
    logic              arm_c;
    logic [CNT_W-1:0]  pix_cnt;

    // Two-flop synchronizer plus one history flop for start-edge detection
    always_ff @(posedge clk) begin
        if (!btnC) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_s_d  <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_s_d  <= rx_s;
        end
    end

    always_ff @(posedge clk) begin
        if (!btnC) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    // Receiver next-state: mid-bit sampling timed from the start-bit falling edge
    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        byte_ok_c  = 1'b0;
        byte_bad_c = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rx_s_d && !rx_s) begin
                    state_d = START;
                    baud_d  = '0;
                end
            end
            START: begin
                if (baud_q == HALF_LAST) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = rx_s ? IDLE : DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (baud_q == BIT_LAST) begin
                    baud_d  = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            STOP: begin
                if (baud_q == BIT_LAST) begin
                    baud_d     = '0;
                    state_d    = IDLE;
                    byte_ok_c  = rx_s;
                    byte_bad_c = !rx_s;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign arm_c = load_en && !load_en_d;

    // Load control: arming wins over a coinciding byte; busy drops the cycle after the last write
    always_ff @(posedge clk) begin
        if (!btnC) begin
            load_en_d <= 1'b0;
            we        <= 1'b0;
            addr      <= '0;
            din       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            frame_err <= 1'b0;
            pix_cnt   <= '0;
        end else begin
            load_en_d <= load_en;
            we        <= 1'b0;
            if (arm_c && !busy) begin
                busy      <= 1'b1;
                done      <= 1'b0;
                frame_err <= 1'b0;
                pix_cnt   <= '0;
            end else begin
                if (busy && we && pix_cnt == PIX_END) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
                if (busy && byte_ok_c && pix_cnt < PIX_END) begin
                    we      <= 1'b1;
                    addr    <= pix_cnt[15:0];
                    din     <= shift_q;
                    pix_cnt <= pix_cnt + 17'd1;
                end
                if (busy && byte_bad_c) begin
                    frame_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_image_loader.sv
// Directed bench for uart_image_loader: a byte-level load model predicts every
// output each cycle; literal checks after each scenario pin the model.
module tb_uart_image_loader;

    localparam int N   = 16;
    localparam int IMG = 4;
    // start-bit drive to stop-bit sample: 2 sync flops + edge detect + half bit + 9 bits
    localparam int LAT = 3 + N / 2 + 9 * N;

    logic        clk = 1'b0;
    logic        btnC;
    logic        rx;
    logic        load_en;
    logic        we;
    logic [15:0] addr;
    logic [7:0]  din;
    logic        busy;
    logic        done;
    logic        frame_err;

    uart_image_loader #(.CLKS_PER_BIT(N), .IMG_PIXELS(IMG)) dut (
        .clk(clk), .btnC(btnC), .rx(rx), .load_en(load_en),
        .we(we), .addr(addr), .din(din),
        .busy(busy), .done(done), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          at_edge;
        logic [7:0]  data;
        logic        ok;
    } ev_t;

    ev_t evq[$];
    ev_t ev;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int wcount = 0;
    int last_we_cyc = 0;
    int last_start = 0;
    logic [15:0] last_addr = '0;
    logic [7:0]  last_din = '0;
    bit cmp_en = 1'b0;

    // model state
    bit          m_we, m_busy, m_done, m_fe, m_fin, m_le_prev;
    int          m_cnt;
    logic [15:0] m_addr;
    logic [7:0]  m_din;
    bit          ev_hit, arm, old_busy;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0h expected=%0h", nm, cyc, act, exp);
        end
    endfunction

    // Load model: advances on each clock edge from the bench's own byte schedule
    always @(posedge clk) begin
        cyc++;
        m_we = 1'b0;
        if (!btnC) begin
            m_busy = 0; m_done = 0; m_fe = 0; m_fin = 0; m_le_prev = 0;
            m_cnt = 0; m_addr = '0; m_din = '0;
            evq.delete();
        end else begin
            ev_hit = (evq.size() > 0) && (evq[0].at_edge == cyc);
            if (ev_hit) ev = evq.pop_front();
            arm = load_en && !m_le_prev;
            m_le_prev = load_en;
            old_busy = m_busy;
            if (m_fin) begin
                m_busy = 0; m_done = 1; m_fin = 0;
            end
            if (arm && !old_busy) begin
                m_busy = 1; m_done = 0; m_fe = 0; m_cnt = 0;
            end else if (ev_hit && old_busy) begin
                if (ev.ok) begin
                    m_we = 1;
                    m_addr = m_cnt[15:0];
                    m_din = ev.data;
                    m_cnt++;
                    m_fin = (m_cnt == IMG);
                end else begin
                    m_fe = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("we", we, m_we);
            chk("addr", addr, m_addr);
            chk("din", din, m_din);
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
            chk("frame_err", frame_err, m_fe);
            if (we === 1'b1) begin
                wcount++;
                last_we_cyc = cyc;
                last_addr = addr;
                last_din = din;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_ok, input int rst_bit);
        @(negedge clk);
        last_start = cyc;
        evq.push_back('{at_edge: cyc + LAT, data: b, ok: stop_ok});
        rx = 1'b0;
        repeat (N) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            if (i == rst_bit) begin
                repeat (N / 2) @(negedge clk);
                btnC = 1'b0;
                @(negedge clk);
                chk("rst_mid_we", we, 0);
                chk("rst_mid_busy", busy, 0);
                chk("rst_mid_addr", addr, 0);
                chk("rst_mid_din", din, 0);
                btnC = 1'b1;
                repeat (N / 2 - 1) @(negedge clk);
            end else begin
                repeat (N) @(negedge clk);
            end
        end
        rx = stop_ok;
        repeat (N) @(negedge clk);
        rx = 1'b1;
        repeat (N) @(negedge clk);
    endtask

    task automatic arm_load();
        @(negedge clk);
        load_en = 1'b1;
        @(negedge clk);
        load_en = 1'b0;
    endtask

    initial begin
        int w0;
        logic [7:0] seq [4];
        rx = 1'b1;
        load_en = 1'b0;
        btnC = 1'b0;
        @(posedge clk);
        cmp_en = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_addr", addr, 0);
        btnC = 1'b1;
        repeat (4) @(negedge clk);

        // unarmed byte is dropped
        w0 = wcount;
        send_byte(8'h55, 1'b1, -1);
        chk("unarmed_writes", wcount - w0, 0);

        // single byte
        arm_load();
        chk("arm_busy", busy, 1);
        w0 = wcount;
        send_byte(8'hA5, 1'b1, -1);
        chk("single_writes", wcount - w0, 1);
        chk("single_addr", last_addr, 16'h0000);
        chk("single_din", last_din, 8'hA5);
        chk("single_latency", last_we_cyc - last_start, 155);
        chk("single_busy", busy, 1);

        // glitch while armed
        w0 = wcount;
        @(negedge clk); rx = 1'b0;
        repeat (4) @(negedge clk); rx = 1'b1;
        repeat (2 * N) @(negedge clk);
        chk("glitch_writes", wcount - w0, 0);
        chk("glitch_fe", frame_err, 0);

        // arm mid-load ignored, counter continues to completion
        arm_load();
        w0 = wcount;
        send_byte(8'h5A, 1'b1, -1);
        chk("midarm_addr", last_addr, 16'h0001);
        send_byte(8'h11, 1'b1, -1);
        send_byte(8'h22, 1'b1, -1);
        chk("fill_writes", wcount - w0, 3);
        chk("fill_addr", last_addr, 16'h0003);
        chk("fill_done", done, 1);
        chk("fill_busy", busy, 0);
        w0 = wcount;
        send_byte(8'h99, 1'b1, -1);
        chk("after_done_writes", wcount - w0, 0);

        // full load after re-arm
        arm_load();
        chk("rearm_done", done, 0);
        seq = '{8'h01, 8'h02, 8'h03, 8'h04};
        w0 = wcount;
        for (int i = 0; i < 4; i++) send_byte(seq[i], 1'b1, -1);
        chk("full_writes", wcount - w0, 4);
        chk("full_addr", last_addr, 16'h0003);
        chk("full_din", last_din, 8'h04);
        chk("full_done", done, 1);
        w0 = wcount;
        send_byte(8'h05, 1'b1, -1);
        chk("fifth_writes", wcount - w0, 0);

        // arm coinciding with a byte's stop sample: arm wins, byte dropped
        w0 = wcount;
        fork
            send_byte(8'h06, 1'b1, -1);
            begin
                repeat (LAT) @(negedge clk);
                load_en = 1'b1;
                @(negedge clk);
                load_en = 1'b0;
            end
        join
        chk("coinc_writes", wcount - w0, 0);
        chk("coinc_busy", busy, 1);
        send_byte(8'h08, 1'b1, -1);
        chk("coinc_next_addr", last_addr, 16'h0000);
        chk("coinc_next_din", last_din, 8'h08);
        for (int i = 0; i < 3; i++) send_byte(8'h09 + 8'(i), 1'b1, -1);
        chk("coinc_fill_done", done, 1);

        // frame error
        arm_load();
        w0 = wcount;
        send_byte(8'h3C, 1'b0, -1);
        chk("fe_writes", wcount - w0, 0);
        chk("fe_flag", frame_err, 1);
        send_byte(8'h7E, 1'b1, -1);
        chk("fe_next_writes", wcount - w0, 1);
        chk("fe_next_addr", last_addr, 16'h0000);
        chk("fe_next_din", last_din, 8'h7E);
        chk("fe_sticky", frame_err, 1);

        // reset during data bit 4
        w0 = wcount;
        send_byte(8'hC3, 1'b1, 4);
        repeat (12 * N) @(negedge clk);
        send_byte(8'h66, 1'b1, -1);
        chk("rst_writes", wcount - w0, 0);
        chk("rst_busy_after", busy, 0);

        // load_en held high through reset arms on release
        @(negedge clk);
        load_en = 1'b1;
        btnC = 1'b0;
        repeat (2) @(negedge clk);
        btnC = 1'b1;
        @(negedge clk);
        chk("hold_arm_busy", busy, 1);
        load_en = 1'b0;
        w0 = wcount;
        send_byte(8'h77, 1'b1, -1);
        chk("hold_writes", wcount - w0, 1);
        chk("hold_addr", last_addr, 16'h0000);
        chk("hold_din", last_din, 8'h77);

        repeat (4) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_image_loader.md
UART_IMAGE_LOADER -- requirements
Module: uart_image_loader

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 868, meaning clk cycles per UART bit (100 MHz / 115200 baud).
REQ-002 The block SHALL have parameter IMG_PIXELS, default 65536, meaning number of 8-bit pixels per image (256x256 grayscale).
REQ-003 The block SHALL have port clk, input, 1 bit, meaning 100 MHz board clock; it is the only clock.
REQ-004 The block SHALL have port btnC, input, 1 bit, meaning reset, synchronous and active-low.
REQ-005 The block SHALL have port rx, input, 1 bit, meaning asynchronous UART serial data, idle high.
REQ-006 The block SHALL have port load_en, input, 1 bit, meaning arms a new image load, sampled on its rising edge.
REQ-007 The block SHALL have port we, output, 1 bit, meaning BRAM write-enable, one-cycle pulse per accepted pixel.
REQ-008 The block SHALL have port addr, output, 16 bits, meaning BRAM write address (pixel index).
REQ-009 The block SHALL have port din, output, 8 bits, meaning BRAM write data (received byte).
REQ-010 The block SHALL have port busy, output, 1 bit, meaning a load is armed and not yet complete.
REQ-011 The block SHALL have port done, output, 1 bit, meaning the last load completed, held until re-armed or reset.
REQ-012 The block SHALL have port frame_err, output, 1 bit, meaning a bad stop bit occurred during the current load (sticky).

Function
REQ-013 The block SHALL pass rx through a 2-flop synchronizer, and all receiver logic SHALL use only the synchronized value rx_s.
REQ-014 The receiver FSM SHALL have states IDLE, START, DATA and STOP, with a baud counter of ceil(log2(CLKS_PER_BIT)) bits and a 3-bit bit index.
REQ-015 In IDLE, the FSM SHALL go to START on a 1-to-0 transition of rx_s and clear the baud counter.
REQ-016 In START, after CLKS_PER_BIT/2 cycles the FSM SHALL sample rx_s: 0 goes to DATA, 1 (glitch) goes back to IDLE without writing.
REQ-017 In DATA, the FSM SHALL sample rx_s every CLKS_PER_BIT cycles, shift LSB first into an 8-bit register, and go to STOP after bit index 7.
REQ-018 In STOP, the FSM SHALL sample rx_s after CLKS_PER_BIT cycles: 1 means the byte is valid, 0 means frame error; either way it returns to IDLE.
REQ-019 When a valid byte arrives while busy=1, the block SHALL, on the cycle after the stop sample, drive we=1 for exactly 1 cycle with din=byte and addr=pixel counter, then increment the counter.
REQ-020 Outside the write cycle, we SHALL be 0, while addr and din hold their last values.
REQ-021 A frame error while busy=1 SHALL discard the byte, leave the counter unchanged, and set frame_err=1 until the next arm or reset.
REQ-022 Valid bytes received while busy=0 SHALL be discarded (no we), and the receiver SHALL keep running so it stays byte-aligned.
REQ-023 A rising edge of load_en while busy=0 SHALL, on the next cycle, set busy=1, clear done, frame_err and the pixel counter.
REQ-024 A rising edge of load_en while busy=1 SHALL be ignored.
REQ-025 If a load_en rising edge and a write pulse coincide with busy=0, arming SHALL take effect and the coinciding byte SHALL NOT be written.
REQ-026 The pixel counter SHALL be 17 bits; addr SHALL equal counter[15:0].
REQ-027 When the write of pixel IMG_PIXELS-1 occurs, the block SHALL, on the next cycle, set busy=0 and done=1; the counter SHALL NOT wrap while busy.
REQ-028 Bytes arriving after done SHALL be discarded per REQ-022.

Reset
REQ-029 While btnC=0 at a clk edge, the block SHALL set FSM=IDLE, counters=0, shift register=0, synchronizer flops=1, we=0, addr=0, din=0, busy=0, done=0 and frame_err=0.
REQ-030 Reset mid-byte or mid-load SHALL abandon the partial byte and the load, with no write pulse; a new arm is required afterwards.
REQ-031 The load_en edge detector SHALL reset its history to 0, so load_en held high through reset arms once on the first cycle after reset release.

Verification
REQ-032 The bench SHALL cover single byte: CLKS_PER_BIT=16, arm, send 0xA5 -> exactly one we pulse, addr=0, din=0xA5, 1 cycle after the stop sample; busy=1.
REQ-033 The bench SHALL cover full load: IMG_PIXELS=4, arm, send 0x01,0x02,0x03,0x04 -> writes at addr 0..3 in order; next cycle busy=0, done=1; a 5th byte produces no we.
REQ-034 The bench SHALL cover frame error: arm, send 0x3C with stop bit=0, then 0x7E -> no write for 0x3C, frame_err=1, 0x7E written at addr 0.
REQ-035 The bench SHALL cover glitch: a 4-cycle low pulse on rx while idle -> FSM returns to IDLE, no we, no frame_err.
REQ-036 The bench SHALL cover unarmed/re-arm: send 0x55 with busy=0 -> no we; arm mid-load -> ignored, counter continues; after done, re-arm -> done=0, next byte at addr 0.
REQ-037 The bench SHALL cover reset mid-byte: btnC=0 during DATA bit 4 -> all outputs at reset values next cycle; the remaining bits produce no write.
